// File: rtl/wb_write_arbiter.sv
// Register-file write-port arbiter: single-cycle ALU results take priority over queued
// load returns, and a 31-entry pending-load scoreboard tracks loads still in flight.

module wb_pend_bit (
  input  logic clk,
  input  logic reset,
  input  logic set,
  input  logic clr,
  output logic pend
);
  // A new issue to this register outranks the drain of its previous load.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)   pend <= 1'b0;
    else if (set) pend <= 1'b1;
    else if (clr) pend <= 1'b0;
  end
endmodule

module wb_write_arbiter #(
  parameter int N     = 32,
  parameter int DEPTH = 2
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         alu_valid,
  input  logic [4:0]   alu_rd,
  input  logic [N-1:0] alu_data,
  input  logic         mem_valid,
  input  logic [4:0]   mem_rd,
  input  logic [N-1:0] mem_data,
  output logic         mem_ready,
  input  logic         issue_valid,
  input  logic [4:0]   issue_rd,
  output logic         write_enable,
  output logic [4:0]   reg_write1,
  output logic [N-1:0] write_data,
  output logic [31:0]  pending_mask
);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef struct packed {
    logic [4:0]   rd;
    logic [N-1:0] data;
  } wb_ent_t;

  wb_ent_t       fifo_q [DEPTH];
  wb_ent_t       head;
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count;
  logic          alu_win, enq, deq;
  logic [31:1]   pend_bits;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign mem_ready = (count < CW'(DEPTH));
  assign alu_win   = alu_valid && (alu_rd != 5'd0);
  // x0 returns complete the handshake but never occupy a slot.
  assign enq       = mem_valid && mem_ready && (mem_rd != 5'd0);
  assign deq       = !alu_win && (count != '0);
  assign head      = fifo_q[rd_ptr];

  // Payload storage needs no reset; count and pointers define validity.
  always_ff @(posedge clk) begin
    if (enq) fifo_q[wr_ptr] <= '{rd: mem_rd, data: mem_data};
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (enq) wr_ptr <= ptr_inc(wr_ptr);
      if (deq) rd_ptr <= ptr_inc(rd_ptr);
      case ({enq, deq})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      write_enable <= 1'b0;
      reg_write1   <= '0;
      write_data   <= '0;
    end else if (alu_win) begin
      write_enable <= 1'b1;
      reg_write1   <= alu_rd;
      write_data   <= alu_data;
    end else if (deq) begin
      write_enable <= 1'b1;
      reg_write1   <= head.rd;
      write_data   <= head.data;
    end else begin
      write_enable <= 1'b0;
    end
  end

  for (genvar r = 1; r < 32; r++) begin : g_pend
    wb_pend_bit u_pend (
      .clk   (clk),
      .reset (reset),
      .set   (issue_valid && (issue_rd == 5'(r))),
      .clr   (deq && (head.rd == 5'(r))),
      .pend  (pend_bits[r])
    );
  end

  assign pending_mask = {pend_bits, 1'b0};
endmodule

// File: tb/tb_wb_write_arbiter.sv
// Directed scenarios plus constrained-random traffic against a queue-based model
// of the write arbiter and its pending-load scoreboard.

module tb_wb_write_arbiter;
  localparam int N = 32, DEPTH = 2;

  logic         clk = 1'b0, reset = 1'b0;
  logic         alu_valid, mem_valid, issue_valid;
  logic [4:0]   alu_rd, mem_rd, issue_rd;
  logic [N-1:0] alu_data, mem_data;
  logic         mem_ready, write_enable;
  logic [4:0]   reg_write1;
  logic [N-1:0] write_data;
  logic [31:0]  pending_mask;

  wb_write_arbiter #(.N(N), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset),
    .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data),
    .mem_valid(mem_valid), .mem_rd(mem_rd), .mem_data(mem_data), .mem_ready(mem_ready),
    .issue_valid(issue_valid), .issue_rd(issue_rd),
    .write_enable(write_enable), .reg_write1(reg_write1), .write_data(write_data),
    .pending_mask(pending_mask)
  );

  always #5 clk = ~clk;

  int n_cmp = 0, n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference model: a queue of pending writes and a plain pending bit array.
  typedef struct { logic [4:0] rd; logic [31:0] d; } ent_t;
  ent_t        mq[$];
  logic [31:0] m_pend;
  logic        m_we;
  logic [4:0]  m_rd;
  logic [31:0] m_data;
  bit          m_acc;

  function automatic void model_reset();
    mq.delete();
    m_pend = '0; m_we = 1'b0; m_rd = '0; m_data = '0; m_acc = 1'b0;
  endfunction

  function automatic void model_edge();
    int   sz = mq.size();
    ent_t e;
    m_acc = mem_valid && (sz < DEPTH);
    if (alu_valid && alu_rd != 0) begin
      m_we = 1'b1; m_rd = alu_rd; m_data = alu_data;
    end else if (sz > 0) begin
      e = mq.pop_front();
      m_we = 1'b1; m_rd = e.rd; m_data = e.d;
      m_pend[e.rd] = 1'b0;
    end else begin
      m_we = 1'b0;
    end
    if (m_acc && mem_rd != 0) mq.push_back('{mem_rd, mem_data});
    if (issue_valid && issue_rd != 0) m_pend[issue_rd] = 1'b1;
  endfunction

  task automatic step();
    model_edge();
    @(posedge clk); #1;
    chk("write_enable", 32'(write_enable), 32'(m_we));
    chk("reg_write1",   32'(reg_write1),   32'(m_rd));
    chk("write_data",   write_data,        m_data);
    chk("pending_mask", pending_mask,      m_pend);
    chk("mem_ready",    32'(mem_ready),    32'(mq.size() < DEPTH));
  endtask

  task automatic idle();
    alu_valid = 0; alu_rd = 0; alu_data = 0;
    mem_valid = 0; mem_rd = 0; mem_data = 0;
    issue_valid = 0; issue_rd = 0;
  endtask

  // Queue two loads (a, b) while an ALU stream keeps the FIFO from draining.
  task automatic fill2(input logic [4:0] a, input logic [4:0] b);
    idle(); issue_valid = 1; issue_rd = a; step();
    issue_rd = b; step();
    idle(); alu_valid = 1; alu_rd = 9; alu_data = $urandom;
    mem_valid = 1; mem_rd = a; mem_data = $urandom; step();
    alu_data = $urandom; mem_rd = b; mem_data = $urandom; step();
    mem_valid = 0;
  endtask

  initial begin
    int         nwr, guard, k, hk;
    logic [4:0] r, i;
    bit         hold;
    int         outst[$];

    // Reset held with random inputs
    model_reset();
    repeat (3) begin
      alu_valid = 1; alu_rd = $urandom; alu_data = $urandom;
      mem_valid = 1; mem_rd = $urandom; mem_data = $urandom;
      issue_valid = 1; issue_rd = $urandom;
      @(posedge clk); #1;
      chk("rst_we",   32'(write_enable), 0);
      chk("rst_rd",   32'(reg_write1),   0);
      chk("rst_data", write_data,        0);
      chk("rst_mask", pending_mask,      0);
    end
    idle(); reset = 1; #1;
    chk("rst_ready", 32'(mem_ready), 1);

    // ALU only
    alu_valid = 1; alu_rd = 5; alu_data = 32'hDEAD_BEEF; step();
    chk("alu_rd5",   32'(reg_write1), 5);
    chk("alu_data5", write_data, 32'hDEAD_BEEF);
    alu_rd = 0; alu_data = 32'h1111_2222; step();
    chk("alu_rd0_we", 32'(write_enable), 0);

    // Load path: issue, gap, return, write
    idle(); issue_valid = 1; issue_rd = 7; step();
    chk("issue7_mask", pending_mask, 32'h80);
    idle(); step();
    mem_valid = 1; mem_rd = 7; mem_data = 32'h1234; step();
    chk("no_bypass", 32'(write_enable), 0);
    idle(); step();
    chk("load7_rd",   32'(reg_write1), 7);
    chk("load7_data", write_data, 32'h1234);
    chk("load7_mask", pending_mask, 0);

    // Backpressure: ALU owns the port while two loads sit in the FIFO
    fill2(3, 4);
    repeat (4) begin
      alu_data = $urandom; step();
      chk("bp_ready", 32'(mem_ready), 0);
      chk("bp_rd", 32'(reg_write1), 9);
    end
    idle(); step();
    chk("drain_x3", 32'(reg_write1), 3);
    step();
    chk("drain_x4", 32'(reg_write1), 4);
    chk("drain_ready", 32'(mem_ready), 1);
    step();

    // Simultaneous enqueue/dequeue, then issue on the draining edge
    idle(); issue_valid = 1; issue_rd = 5; step();
    issue_rd = 6; step();
    idle(); alu_valid = 1; alu_rd = 9; alu_data = $urandom;
    mem_valid = 1; mem_rd = 5; mem_data = $urandom; step();
    idle(); mem_valid = 1; mem_rd = 6; mem_data = 32'h6666; step();
    chk("sim_deq5", 32'(reg_write1), 5);
    chk("sim_ready", 32'(mem_ready), 1);
    idle(); issue_valid = 1; issue_rd = 6; step();
    chk("sim_deq6", 32'(reg_write1), 6);
    chk("sim_setwins", 32'(pending_mask[6]), 1);
    idle(); step();

    // Mid-operation async reset with two queued entries
    fill2(11, 12);
    idle(); #2 reset = 0; #1;
    chk("mid_rst_mask", pending_mask, 0);
    chk("mid_rst_we", 32'(write_enable), 0);
    chk("mid_rst_ready", 32'(mem_ready), 1);
    model_reset();
    @(posedge clk); #1 reset = 1;
    step();

    // Wrap: ten back-to-back loads through the two-entry FIFO
    for (int j = 1; j <= 10; j++) begin
      idle(); issue_valid = 1; issue_rd = 5'(j); step();
    end
    idle(); i = 1; nwr = 0; guard = 0;
    while (i <= 10 && guard < 100) begin
      mem_valid = 1; mem_rd = i; mem_data = $urandom; step();
      if (m_acc) i++;
      if (write_enable) nwr++;
      guard++;
    end
    idle();
    repeat (2) begin step(); if (write_enable) nwr++; end
    chk("wrap_accepts", 32'(i), 11);
    chk("wrap_writes", 32'(nwr), 10);
    chk("wrap_mask", pending_mask, 0);

    // Discarded x0 return
    mem_valid = 1; mem_rd = 0; mem_data = 32'hBAD0_BAD0; step();
    chk("x0_ready", 32'(mem_ready), 1);
    idle(); step();
    chk("x0_no_write", 32'(write_enable), 0);

    // Constrained random traffic
    hold = 0; hk = -1;
    for (int c = 0; c < 3000; c++) begin
      issue_valid = 0; issue_rd = 0;
      if ($urandom_range(0, 3) == 0) begin
        r = 5'($urandom_range(1, 31));
        if (!m_pend[r]) begin issue_valid = 1; issue_rd = r; end
      end
      alu_valid = ($urandom_range(0, 2) == 0);
      alu_rd = 5'($urandom_range(0, 31));
      if (m_pend[alu_rd] || (issue_valid && alu_rd == issue_rd)) alu_rd = 0;
      alu_data = $urandom;
      if (!hold) begin
        if (outst.size() > 0 && $urandom_range(0, 1) == 1) begin
          k = $urandom_range(0, outst.size() - 1);
          mem_valid = 1; mem_rd = 5'(outst[k]); mem_data = $urandom; hold = 1; hk = k;
        end else if ($urandom_range(0, 15) == 0) begin
          mem_valid = 1; mem_rd = 0; mem_data = $urandom; hold = 1; hk = -1;
        end else begin
          mem_valid = 0;
        end
      end
      step();
      if (hold && m_acc) begin
        if (hk >= 0) outst.delete(hk);
        hold = 0; mem_valid = 0;
      end
      if (issue_valid && issue_rd != 0) outst.push_back(int'(issue_rd));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
